// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000 bus target: FSM state encoding,
// function-code decode and byte-enable bit positions.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STROBE,
        ST_MEM,
        ST_ACK,
        ST_IACK,
        ST_ERR,
        ST_DRAIN
    } state_t;

    localparam logic [2:0] FC_IACK  = 3'b111;
    localparam int         BE_UPPER = 1;
    localparam int         BE_LOWER = 0;
    localparam int         TMR_W    = 10;   // wide enough for TIMEOUT_CYCLES up to 1023

    function automatic logic [1:0] strobe_be(input logic uds_n, input logic lds_n);
        logic [1:0] be;
        be           = '0;
        be[BE_UPPER] = ~uds_n;
        be[BE_LOWER] = ~lds_n;
        return be;
    endfunction

endpackage

// File: rtl/m68k_berr_timer.sv
// Bus-error watchdog: counts clk cycles from start and flags expired after
// TIMEOUT_CYCLES edges. Only instantiated when TGT_BERR_TIMEOUT_EN is defined.
module m68k_berr_timer
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic expired
);

    logic [TMR_W-1:0] count;
    logic             running;

    // count is 0 on the cycle after start, so the owner sees expired during
    // cycle TIMEOUT_CYCLES-1 and reacts on the TIMEOUT_CYCLES-th edge.
    assign expired = running && (count == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            count   <= '0;
        end else if (start) begin
            running <= 1'b1;
            count   <= '0;
        end else if (clear) begin
            running <= 1'b0;
            count   <= '0;
        end else if (running && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/m68k_bus_target.sv
// 68000 asynchronous-bus target bridging to a req/ack memory port.
// Optional bus-error timeout enabled by defining TGT_BERR_TIMEOUT_EN.
module m68k_bus_target
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as_n,
    input  logic        rw_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic [2:0]  fc,
    input  logic [22:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        dtack_n,
    output logic        vpa_n,
    output logic        berr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("m68k_bus_target: TIMEOUT_CYCLES must be in 4..1023");
    end

    state_t state;
    logic   strobe_low;
    logic   timeout;

    assign strobe_low = !(uds_n && lds_n);

`ifdef TGT_BERR_TIMEOUT_EN
    logic timer_start;
    logic timer_clear;

    // Restart on every entry into STROBE or MEM; start wins over clear.
    assign timer_start = !as_n && (((state == ST_IDLE) && (fc != FC_IACK)) ||
                                   ((state == ST_STROBE) && strobe_low));
    assign timer_clear = (state != ST_STROBE) && (state != ST_MEM);

    m68k_berr_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_berr_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (timer_start),
        .clear  (timer_clear),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // NOTE: all state and outputs are registered with non-blocking assignments
    // so every branch below sees the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rdata     <= '0;
            dtack_n   <= 1'b1;
            vpa_n     <= 1'b1;
            berr      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!as_n) begin
                        if (fc == FC_IACK) begin
                            vpa_n <= 1'b0;
                            state <= ST_IACK;
                        end else if (strobe_low) begin
                            mem_addr  <= addr;
                            mem_be    <= strobe_be(uds_n, lds_n);
                            mem_wdata <= wdata;
                            mem_we    <= ~rw_n;
                            mem_req   <= 1'b1;
                            state     <= ST_MEM;
                        end else begin
                            state <= ST_STROBE;
                        end
                    end
                end
                ST_STROBE: begin
                    if (as_n) begin
                        state <= ST_IDLE;
                    end else if (strobe_low) begin
                        mem_addr  <= addr;
                        mem_be    <= strobe_be(uds_n, lds_n);
                        mem_wdata <= wdata;
                        mem_we    <= ~rw_n;
                        mem_req   <= 1'b1;
                        state     <= ST_MEM;
                    end else if (timeout) begin
                        berr  <= 1'b1;
                        state <= ST_ERR;
                    end
                end
                ST_MEM: begin
                    // An ack coinciding with timeout still completes normally;
                    // an ack coinciding with as_n release completes silently.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!as_n) begin
                            if (!mem_we) rdata <= mem_rdata;
                            dtack_n <= 1'b0;
                            state   <= ST_ACK;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (as_n) begin
                        state <= ST_DRAIN;
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        berr    <= 1'b1;
                        state   <= ST_ERR;
                    end
                end
                ST_ACK: begin
                    if (as_n) begin
                        dtack_n <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_IACK: begin
                    if (as_n) begin
                        vpa_n <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (as_n) begin
                        berr  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_target.sv
// Directed bench for m68k_bus_target: cycle-vector table for read, byte write
// and interrupt acknowledge, plus hand sequences for abort, stall/timeout, reset.
module tb_m68k_bus_target;

    logic        clk = 1'b0;
    logic        reset;
    logic        as_n, rw_n, uds_n, lds_n;
    logic [2:0]  fc;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        dtack_n, vpa_n, berr;
    logic        mem_req, mem_we;
    logic [22:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    m68k_bus_target #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .as_n     (as_n),
        .rw_n     (rw_n),
        .uds_n    (uds_n),
        .lds_n    (lds_n),
        .fc       (fc),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .dtack_n  (dtack_n),
        .vpa_n    (vpa_n),
        .berr     (berr),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_be   (mem_be),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    typedef struct {
        logic        as_n, rw_n, uds_n, lds_n;
        logic [2:0]  fc;
        logic [22:0] addr;
        logic [15:0] wdata;
        logic        mem_ack;
        logic [15:0] mem_rdata;
        logic        e_dtack_n, e_vpa_n, e_berr, e_mem_req, e_mem_we;
        logic [1:0]  e_mem_be;
        logic [15:0] e_rdata;
        logic [22:0] e_mem_addr;
        logic [15:0] e_mem_wdata;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic a, input logic r, input logic u, input logic l,
                           input logic [2:0] f, input logic [22:0] ad, input logic [15:0] wd);
        as_n = a; rw_n = r; uds_n = u; lds_n = l; fc = f; addr = ad; wdata = wd;
    endtask

    task automatic set_mem(input logic ack, input logic [15:0] rd);
        mem_ack = ack; mem_rdata = rd;
    endtask

    task automatic set_idle();
        set_bus(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 23'h0, 16'h0);
    endtask

    task automatic check_exclusive(input string tag);
        logic [1:0] n_active;
        n_active = 2'(!dtack_n) + 2'(!vpa_n) + 2'(berr);
        check({tag, " exclusive"}, 32'(n_active <= 2'd1), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " dtack_n"}, 32'(dtack_n), 32'd1);
        check({tag, " vpa_n"},   32'(vpa_n),   32'd1);
        check({tag, " berr"},    32'(berr),    32'd0);
        check({tag, " mem_req"}, 32'(mem_req), 32'd0);
        check({tag, " mem_we"},  32'(mem_we),  32'd0);
        check({tag, " mem_be"},  32'(mem_be),  32'd0);
        check({tag, " rdata"},   32'(rdata),   32'd0);
    endtask

    initial begin
        // Read of 0x000100 (minimum latency), byte write with delayed strobe,
        // IACK with a stray mem_ack, and a stray mem_ack in IDLE.
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,3'd5,23'h100,16'h0000,1'b0,16'h0000,
                     1'b1,1'b1,1'b0,1'b1,1'b0,2'b11,16'h0000,23'h100,16'h0000};
        vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,3'd5,23'h100,16'h0000,1'b1,16'hBEEF,
                     1'b0,1'b1,1'b0,1'b0,1'b0,2'b11,16'hBEEF,23'h100,16'h0000};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,3'd5,23'h100,16'h0000,1'b0,16'h0000,
                     1'b0,1'b1,1'b0,1'b0,1'b0,2'b11,16'hBEEF,23'h100,16'h0000};
        vecs[3]  = '{1'b1,1'b1,1'b1,1'b1,3'd5,23'h100,16'h0000,1'b0,16'h0000,
                     1'b1,1'b1,1'b0,1'b0,1'b0,2'b11,16'hBEEF,23'h100,16'h0000};
        vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,3'd5,23'h200,16'h1234,1'b0,16'h0000,
                     1'b1,1'b1,1'b0,1'b0,1'b0,2'b11,16'hBEEF,23'h100,16'h0000};
        vecs[5]  = '{1'b0,1'b0,1'b1,1'b1,3'd5,23'h200,16'h1234,1'b0,16'h0000,
                     1'b1,1'b1,1'b0,1'b0,1'b0,2'b11,16'hBEEF,23'h100,16'h0000};
        vecs[6]  = '{1'b0,1'b0,1'b1,1'b0,3'd5,23'h200,16'h00A5,1'b0,16'h0000,
                     1'b1,1'b1,1'b0,1'b1,1'b1,2'b01,16'hBEEF,23'h200,16'h00A5};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,3'd5,23'h200,16'h00A5,1'b1,16'hDEAD,
                     1'b0,1'b1,1'b0,1'b0,1'b1,2'b01,16'hBEEF,23'h200,16'h00A5};
        vecs[8]  = '{1'b1,1'b1,1'b1,1'b1,3'd5,23'h200,16'h0000,1'b0,16'h0000,
                     1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,16'hBEEF,23'h200,16'h00A5};
        vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,3'd7,23'h003,16'h0000,1'b1,16'h7777,
                     1'b1,1'b0,1'b0,1'b0,1'b1,2'b01,16'hBEEF,23'h200,16'h00A5};
        vecs[10] = '{1'b0,1'b1,1'b1,1'b0,3'd7,23'h003,16'h0000,1'b0,16'h0000,
                     1'b1,1'b0,1'b0,1'b0,1'b1,2'b01,16'hBEEF,23'h200,16'h00A5};
        vecs[11] = '{1'b1,1'b1,1'b1,1'b1,3'd5,23'h003,16'h0000,1'b0,16'h0000,
                     1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,16'hBEEF,23'h200,16'h00A5};
        vecs[12] = '{1'b1,1'b1,1'b1,1'b1,3'd5,23'h000,16'h0000,1'b1,16'h1111,
                     1'b1,1'b1,1'b0,1'b0,1'b1,2'b01,16'hBEEF,23'h200,16'h00A5};

        reset = 1'b1;
        set_idle();
        set_mem(1'b0, 16'h0);
        step();
        step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            set_bus(vecs[i].as_n, vecs[i].rw_n, vecs[i].uds_n, vecs[i].lds_n,
                    vecs[i].fc, vecs[i].addr, vecs[i].wdata);
            set_mem(vecs[i].mem_ack, vecs[i].mem_rdata);
            step();
            check($sformatf("v%0d dtack_n", i),   32'(dtack_n),   32'(vecs[i].e_dtack_n));
            check($sformatf("v%0d vpa_n", i),     32'(vpa_n),     32'(vecs[i].e_vpa_n));
            check($sformatf("v%0d berr", i),      32'(berr),      32'(vecs[i].e_berr));
            check($sformatf("v%0d mem_req", i),   32'(mem_req),   32'(vecs[i].e_mem_req));
            check($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vecs[i].e_mem_we));
            check($sformatf("v%0d mem_be", i),    32'(mem_be),    32'(vecs[i].e_mem_be));
            check($sformatf("v%0d rdata", i),     32'(rdata),     32'(vecs[i].e_rdata));
            check($sformatf("v%0d mem_addr", i),  32'(mem_addr),  32'(vecs[i].e_mem_addr));
            check($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_mem_wdata));
            check_exclusive($sformatf("v%0d", i));
        end

        // Abort: as_n released in MEM -> DRAIN holds mem_req until ack, no dtack_n.
        set_bus(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 23'h300, 16'h0);
        set_mem(1'b0, 16'h0);
        step();
        check("abort req", 32'(mem_req), 32'd1);
        set_idle();
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("drain%0d req", k),   32'(mem_req), 32'd1);
            check($sformatf("drain%0d dtack", k), 32'(dtack_n), 32'd1);
        end
        set_mem(1'b1, 16'h5555);
        step();
        check("drain ack req",   32'(mem_req), 32'd0);
        check("drain ack dtack", 32'(dtack_n), 32'd1);
        check("drain ack rdata", 32'(rdata),   32'hBEEF);
        set_mem(1'b0, 16'h0);
        step();
        check("drain done dtack", 32'(dtack_n), 32'd1);

        // Back in IDLE: a fresh read is accepted.
        set_bus(1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 23'h310, 16'h0);
        step();
        check("reread req",  32'(mem_req),  32'd1);
        check("reread addr", 32'(mem_addr), 32'h310);
        check("reread be",   32'(mem_be),   32'b01);
        set_mem(1'b1, 16'h0042);
        step();
        check("reread dtack", 32'(dtack_n), 32'd0);
        check("reread rdata", 32'(rdata),   32'h0042);
        set_mem(1'b0, 16'h0);
        set_idle();
        step();
        check("reread release", 32'(dtack_n), 32'd1);

        set_bus(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 23'h500, 16'h0);
        step();
        check("stall req", 32'(mem_req), 32'd1);
`ifdef TGT_BERR_TIMEOUT_EN
        // berr appears on the 8th edge after mem_req rose.
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("to%0d berr", k),  32'(berr),    32'(k == 8));
            check($sformatf("to%0d req", k),   32'(mem_req), 32'(k != 8));
            check($sformatf("to%0d dtack", k), 32'(dtack_n), 32'd1);
        end
        step();
        check("err hold berr", 32'(berr), 32'd1);
        set_idle();
        step();
        check("err release berr", 32'(berr), 32'd0);
        set_mem(1'b1, 16'hCAFE);
        step();
        check("late ack dtack", 32'(dtack_n), 32'd1);
        check("late ack rdata", 32'(rdata),   32'h0042);
        set_mem(1'b0, 16'h0);
`else
        // Without the timeout, MEM waits indefinitely and berr never asserts.
        for (int k = 1; k <= 20; k++) begin
            step();
            check($sformatf("stall%0d berr", k), 32'(berr),    32'd0);
            check($sformatf("stall%0d req", k),  32'(mem_req), 32'd1);
        end
        set_mem(1'b1, 16'hCAFE);
        step();
        check("stall ack dtack", 32'(dtack_n), 32'd0);
        check("stall ack rdata", 32'(rdata),   32'hCAFE);
        set_mem(1'b0, 16'h0);
        set_idle();
        step();
        check("stall release", 32'(dtack_n), 32'd1);
`endif

        // Reset in MEM: outputs to reset values next cycle, later ack ignored.
        set_bus(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 23'h400, 16'h0);
        step();
        check("rst mem req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        step();
        check_reset_outputs("midrst");
        reset = 1'b0;
        set_idle();
        set_mem(1'b1, 16'h9999);
        step();
        check("post rst dtack", 32'(dtack_n), 32'd1);
        check("post rst req",   32'(mem_req), 32'd0);
        check("post rst rdata", 32'(rdata),   32'd0);
        set_mem(1'b0, 16'h0);
        step();
        check("post rst dtack2", 32'(dtack_n), 32'd1);
        check_exclusive("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m68k_bus_target.md
M68K_BUS_TARGET -- requirements
Module: m68k_bus_target

Interface
REQ-001 TIMEOUT_CYCLES, 255: clk cycles from strobe decode to BERR; legal range 4..1023.
REQ-002 clk  in  1  system clock; all logic on the rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 as_n, rw_n, uds_n, lds_n  in  1 each  68000 bus strobes from the initiator, already in the clk domain.
REQ-005 fc  in  3  function code; 3'b111 = interrupt acknowledge.
REQ-006 addr  in  23  word address A23..A1.
REQ-007 wdata  in  16  initiator write data.
REQ-008 rdata  out  16  read data to the initiator.
REQ-009 dtack_n  out  1  data acknowledge.
REQ-010 vpa_n  out  1  valid peripheral address; requests an autovector.
REQ-011 berr  out  1  bus error, active-high.
REQ-012 mem_req  out  1  memory request; held until acknowledged.
REQ-013 mem_we  out  1  write request.
REQ-014 mem_addr  out  23  latched word address.
REQ-015 mem_be  out  2  byte enables: [1] = upper byte (~uds_n), [0] = lower byte (~lds_n).
REQ-016 mem_wdata  out  16  latched write data.
REQ-017 mem_rdata  in  16  memory read data; valid when mem_ack = 1.
REQ-018 mem_ack  in  1  one-cycle memory acknowledge.

Function
REQ-019 State machine states: IDLE, STROBE, MEM, ACK, IACK, ERR, DRAIN.
REQ-020 IDLE, as_n = 0, fc = 7: next state IACK; vpa_n = 0 from the next cycle.
REQ-021 IDLE, as_n = 0, fc != 7, uds_n & lds_n = 0: latch addr, rw_n, strobes and wdata; set mem_req = 1 and mem_we = ~rw_n; next state MEM.
REQ-022 IDLE, as_n = 0, both data strobes high (write data-strobe delay): next state STROBE; on the first strobe-low cycle, latch and request exactly as in REQ-021.
REQ-023 MEM, mem_ack = 1: mem_req = 0; if a read, rdata = mem_rdata; dtack_n = 0 next cycle; next state ACK.
REQ-024 Minimum read latency: as_n and strobes low in cycle 0, mem_ack in cycle 1 -> dtack_n low in cycle 2.
REQ-025 ACK and IACK: hold dtack_n or vpa_n low until as_n = 1 is sampled; deassert on the next edge; next state IDLE.
REQ-026 rdata holds its last value outside ACK.
REQ-027 as_n rising in STROBE: return to IDLE with no memory request.
REQ-028 as_n rising in MEM: next state DRAIN; keep mem_req until mem_ack; discard the data; no dtack_n; next state IDLE.
REQ-029 mem_ack arriving in any state other than MEM or DRAIN is ignored.
REQ-030 At most one memory request is outstanding; a new cycle cannot be accepted until the state machine reaches IDLE.
REQ-031 dtack_n, vpa_n and berr are mutually exclusive in every cycle.

Reset
REQ-032 Reset forces state IDLE and outputs dtack_n = 1, vpa_n = 1, berr = 0, mem_req = 0, mem_we = 0, mem_be = 0, rdata = 0; the timeout counter is cleared.
REQ-033 Reset asserted mid-transaction abandons any pending mem_ack; no acknowledge is issued after reset deasserts.

Configuration
REQ-034 Macro TGT_BERR_TIMEOUT_EN defined: a counter starts on entry to STROBE or MEM.
REQ-035 With the macro, when the counter reaches TIMEOUT_CYCLES: mem_req = 0, berr = 1, next state ERR; berr holds until as_n = 1, then IDLE.
REQ-036 With the macro, a mem_ack in the same cycle as timeout wins and the normal acknowledge (REQ-023) occurs.
REQ-037 Macro undefined: no counter, berr tied to 0, states STROBE and MEM wait indefinitely.

Structure
REQ-038 Package m68k_bus_pkg holds: the state enum, FC_IACK = 3'b111, and the byte-enable index constants.
REQ-039 The timeout counter is sub-module m68k_berr_timer (start, clear, expired), instantiated only when TGT_BERR_TIMEOUT_EN is defined.

Verification
REQ-040 Read: addr 0x000100, uds_n = lds_n = 0, mem_ack one cycle later with mem_rdata 0xBEEF -> mem_be 2'b11, rdata 0xBEEF, dtack_n low until as_n rises.
REQ-041 Byte write: as_n low, strobes high for 2 cycles, then lds_n low with wdata 0x00A5 -> mem_req starts only after lds_n low; mem_we 1, mem_be 2'b01, mem_wdata 0x00A5.
REQ-042 IACK: fc 7, addr[3:1] = 3 -> vpa_n low and no mem_req; released one cycle after as_n rises.
REQ-043 Timeout (macro defined, TIMEOUT_CYCLES 8): mem_ack never asserted -> berr = 1 eight cycles after mem_req; mem_req drops; dtack_n stays high.
REQ-044 Abort and reset: as_n rises while in MEM -> no dtack_n, and mem_req stays high until mem_ack. Separately, reset during MEM -> all outputs at reset values on the next cycle, and a later mem_ack is ignored.
